// File: rtl/mdu_iter.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Define MDU_DIV_EN to build the divider (DIV/DIVU); without it those functs are ignored.
module mdu_iter #(
  parameter int N    = 32,
  parameter int NSel = 6
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [NSel-1:0] i_funct,
  input  logic [N-1:0]    i_A,
  input  logic [N-1:0]    i_B,
  output logic            o_busy,
  output logic            o_done,
  output logic [N-1:0]    o_hi,
  output logic [N-1:0]    o_lo,
  output logic [2:0]      o_dbg_state
);
  localparam int CW = $clog2(N);
  localparam logic [NSel-1:0] F_MULT  = NSel'(6'b011000);
  localparam logic [NSel-1:0] F_MULTU = NSel'(6'b011001);
  localparam logic [NSel-1:0] F_MTHI  = NSel'(6'b010001);
  localparam logic [NSel-1:0] F_MTLO  = NSel'(6'b010011);
`ifdef MDU_DIV_EN
  localparam logic [NSel-1:0] F_DIV   = NSel'(6'b011010);
  localparam logic [NSel-1:0] F_DIVU  = NSel'(6'b011011);
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
`ifdef MDU_DIV_EN
    S_DIV  = 3'd2,
`endif
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]  acc_q, acc_d;   // product, or {remainder, quotient}
  logic [2*N-1:0]  x_q, x_d;       // shifted multiplicand, or dividend in the low half
  logic [N-1:0]    y_q, y_d;       // multiplier shifting right, or divisor
  logic            neg_res_q, neg_res_d;
  logic [N-1:0]    hi_q, hi_d, lo_q, lo_d;

  logic            is_mul, sgn_op;
  logic [N-1:0]    mag_a, mag_b;
  logic [2*N-1:0]  mul_acc, prod;

  assign is_mul  = (i_funct == F_MULT) || (i_funct == F_MULTU);
  // Signed variants have funct bit 0 clear (MULT/DIV).
  assign sgn_op  = ~i_funct[0];
  assign mag_a   = (sgn_op && i_A[N-1]) ? (-i_A) : i_A;
  assign mag_b   = (sgn_op && i_B[N-1]) ? (-i_B) : i_B;
  assign mul_acc = acc_q + (y_q[0] ? x_q : '0);
  assign prod    = neg_res_q ? (-acc_q) : acc_q;

`ifdef MDU_DIV_EN
  logic            div_op_q, div_op_d;
  logic            neg_rem_q, neg_rem_d;
  logic            dz_q, dz_d;
  logic            is_div;
  logic [N-1:0]    rem, quo, rem_new;
  logic [N:0]      shifted, diff;

  assign is_div  = (i_funct == F_DIV) || (i_funct == F_DIVU);
  assign rem     = acc_q[2*N-1:N];
  assign quo     = acc_q[N-1:0];
  assign shifted = {rem, x_q[N-1]};
  assign diff    = shifted - {1'b0, y_q};
  // A borrow out of the trial subtract means the divisor did not fit: restore.
  assign rem_new = diff[N] ? shifted[N-1:0] : diff[N-1:0];
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      neg_res_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MDU_DIV_EN
      div_op_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      x_q       <= x_d;
      y_q       <= y_d;
      neg_res_q <= neg_res_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MDU_DIV_EN
      div_op_q  <= div_op_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    x_d       = x_q;
    y_d       = y_q;
    neg_res_d = neg_res_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
`ifdef MDU_DIV_EN
    div_op_d  = div_op_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (is_mul) begin
            state_d   = S_MUL;
            cnt_d     = '0;
            acc_d     = '0;
            x_d       = {{N{1'b0}}, mag_a};
            y_d       = mag_b;
            neg_res_d = sgn_op & (i_A[N-1] ^ i_B[N-1]);
`ifdef MDU_DIV_EN
            div_op_d  = 1'b0;
`endif
          end
`ifdef MDU_DIV_EN
          else if (is_div) begin
            state_d   = S_DIV;
            cnt_d     = '0;
            acc_d     = '0;
            x_d       = {{N{1'b0}}, mag_a};
            y_d       = mag_b;
            neg_res_d = sgn_op & (i_A[N-1] ^ i_B[N-1]);
            neg_rem_d = sgn_op & i_A[N-1];
            dz_d      = (i_B == '0);
            div_op_d  = 1'b1;
          end
`endif
          else if (i_funct == F_MTHI) begin
            hi_d = i_A;
          end else if (i_funct == F_MTLO) begin
            lo_d = i_A;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_acc;
        x_d   = x_q << 1;
        y_d   = y_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = S_FIX;
      end
`ifdef MDU_DIV_EN
      S_DIV: begin
        acc_d = {rem_new, acc_q[N-2:0], ~diff[N]};
        x_d   = x_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = S_FIX;
      end
`endif
      S_FIX: begin
        state_d = S_DONE;
`ifdef MDU_DIV_EN
        // A zero divisor leaves rem = |A|, so the normal remainder fix-up returns A.
        if (div_op_q) begin
          lo_d = dz_q ? '1 : (neg_res_q ? (-quo) : quo);
          hi_d = neg_rem_q ? (-rem) : rem;
        end else
`endif
        begin
          hi_d = prod[2*N-1:N];
          lo_d = prod[N-1:0];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);
  assign o_hi        = hi_q;
  assign o_lo        = lo_q;
  assign o_dbg_state = state_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: scoreboard of expected {HI,LO} per multiply/divide plus
// checks of latency, busy window, MTHI/MTLO, ignored starts and mid-operation reset.
module tb_mdu_iter;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [5:0]  i_funct;
  logic [31:0] i_A, i_B;
  logic        o_busy, o_done;
  logic [31:0] o_hi, o_lo;
  logic [2:0]  o_dbg_state;

  logic [63:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  logic [31:0] cur_hi = 32'h0;
  logic [31:0] cur_lo = 32'h0;

  mdu_iter #(.N(32), .NSel(6)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (i_start),
    .i_funct     (i_funct),
    .i_A         (i_A),
    .i_B         (i_B),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_hi        (o_hi),
    .o_lo        (o_lo),
    .o_dbg_state (o_dbg_state)
  );

  // clock / done-pulse counter
  always #5 clk = ~clk;
  always @(posedge clk) if (o_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mul_model(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ea, eb;
    if (f == F_MULT) begin
      ea = {{32{a[31]}}, a};
      eb = {{32{b[31]}}, b};
    end else begin
      ea = {32'h0, a};
      eb = {32'h0, b};
    end
    return ea * eb;
  endfunction

  function automatic logic [63:0] div_model(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (f == F_DIV) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Drive one MDU op, push its expectation, wait for done, then check timing and result.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit inject, input string tag);
    int lat;
    int busy_n;
    bit got;
    logic [63:0] e;
    @(negedge clk);
    i_start = 1'b1; i_funct = f; i_A = a; i_B = b;
    exp_q.push_back(exp);
    @(negedge clk);
    i_start = 1'b0; i_A = $urandom; i_B = $urandom;
    lat = 1; busy_n = 0; got = 1'b0;
    while (lat <= 60 && !got) begin
      if (inject) begin
        case (lat)
          5:  begin i_start = 1'b1; i_funct = F_DIVU; i_A = 32'd9; i_B = 32'd3; end
          6:  i_funct = F_MTHI;
          7:  i_funct = F_MULT;
          8:  i_start = 1'b0;
          10: chk({tag, "_hold"}, {o_hi, o_lo}, {cur_hi, cur_lo});
          default: ;
        endcase
      end
      if (o_busy === 1'b1) busy_n++;
      if (o_done === 1'b1) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_latency"}, 64'(lat), 64'd34);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd34);
    e = exp;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_hilo"}, {o_hi, o_lo}, e);
    end
    cur_hi = e[63:32];
    cur_lo = e[31:0];
    @(negedge clk);
    chk({tag, "_idle_after"}, 64'({o_busy, o_done}), 64'd0);
  endtask

  initial begin
    int d0;
    logic [5:0] f;
    logic [31:0] a, b;

    rst = 1'b1; i_start = 1'b0; i_funct = 6'h0; i_A = 32'h0; i_B = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_hilo", {o_hi, o_lo}, 64'd0);
    chk("rst_state", 64'(o_dbg_state), 64'd0);
    rst = 1'b0;

    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, "multu_max");
    run_op(F_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, "mult_neg");
`ifdef MDU_DIV_EN
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, "div_neg");
    run_op(F_DIVU, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1'b0, "divu_zero");
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, "div_ovf");
    for (int i = 0; i < 4; i++) begin
      f = ($urandom_range(0, 1) == 1) ? F_DIV : F_DIVU;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom_range(1, 1000);
      if ($urandom_range(0, 1) == 1) b = -b;
      run_op(f, a, b, div_model(f, a, b), 1'b0, "div_rand");
    end
`endif
    for (int i = 0; i < 4; i++) begin
      f = ($urandom_range(0, 1) == 1) ? F_MULT : F_MULTU;
      a = $urandom;
      b = $urandom;
      run_op(f, a, b, mul_model(f, a, b), 1'b0, "mul_rand");
    end

    // MTHI then MTLO in back-to-back idle cycles
    d0 = done_cnt;
    @(negedge clk);
    i_start = 1'b1; i_funct = F_MTHI; i_A = 32'h1234; i_B = 32'h0;
    @(negedge clk);
    chk("mthi_hi", 64'(o_hi), 64'h1234);
    chk("mthi_lo_kept", 64'(o_lo), 64'(cur_lo));
    chk("mthi_busy", 64'(o_busy), 64'd0);
    i_funct = F_MTLO; i_A = 32'hABCD;
    @(negedge clk);
    i_start = 1'b0;
    chk("mtlo_hilo", {o_hi, o_lo}, 64'h0000_1234_0000_ABCD);
    chk("mtlo_busy", 64'(o_busy), 64'd0);
    cur_hi = 32'h1234;
    cur_lo = 32'hABCD;

    // unrelated funct is a no-op
    @(negedge clk);
    i_start = 1'b1; i_funct = 6'b100000; i_A = 32'h5555; i_B = 32'h1;
    @(negedge clk);
    i_start = 1'b0;
    chk("other_busy", 64'(o_busy), 64'd0);
    chk("other_hilo", {o_hi, o_lo}, {cur_hi, cur_lo});

`ifndef MDU_DIV_EN
    @(negedge clk);
    i_start = 1'b1; i_funct = F_DIVU; i_A = 32'd100; i_B = 32'd7;
    @(negedge clk);
    i_start = 1'b0;
    chk("nodiv_busy", 64'(o_busy), 64'd0);
    repeat (40) @(negedge clk);
    chk("nodiv_busy_late", 64'(o_busy), 64'd0);
    chk("nodiv_hilo", {o_hi, o_lo}, {cur_hi, cur_lo});
`endif
    chk("mt_no_done", 64'(done_cnt - d0), 64'd0);

    // starts while busy are ignored, HI/LO held until FIX
    d0 = done_cnt;
    run_op(F_MULTU, 32'd3, 32'd4, 64'd12, 1'b1, "busy_ignore");
    repeat (3) @(negedge clk);
    chk("busy_ignore_single_done", 64'(done_cnt - d0), 64'd1);
    chk("busy_ignore_idle", 64'(o_busy), 64'd0);

    // reset mid-operation
`ifdef MDU_DIV_EN
    f = F_DIVU;
`else
    f = F_MULTU;
`endif
    @(negedge clk);
    i_start = 1'b1; i_funct = f; i_A = 32'd100; i_B = 32'd7;
    @(negedge clk);
    i_start = 1'b0;
    d0 = done_cnt;
    repeat (9) @(negedge clk);
    chk("midrst_busy_before", 64'(o_busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_hilo", {o_hi, o_lo}, 64'd0);
    chk("midrst_state", 64'(o_dbg_state), 64'd0);
    cur_hi = 32'h0;
    cur_lo = 32'h0;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("midrst_hilo_late", {o_hi, o_lo}, 64'd0);

    a = $urandom;
    b = $urandom;
    run_op(F_MULT, a, b, mul_model(F_MULT, a, b), 1'b0, "after_rst");
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
